d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 48 ++++
 tb/tb_d_flip_flop.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// d_flip_flop: WIDTH-bit edge-triggered D register with an asynchronous active-low clear.
// Q is the register itself and Qbar is its bitwise complement.
// Optional build macro D_FLIP_FLOP_RST_SYNC_EN adds a two-stage reset-release
// synchronizer so the block can take an unsynchronized board-level reset directly.
module d_flip_flop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    // Reset seen by the data register
    logic rst_n;

`ifdef D_FLIP_FLOP_RST_SYNC_EN
    logic [1:0] rst_sync_q;

    // Clear at once on reset, then shift ones in so release lands two edges after reset rises
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];
`else
    assign rst_n = reset;
`endif

    // Data register: load D on every rising edge, forced to RESET_VALUE while reset is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= D;
        end
    end

    // Complement output carries no state of its own
    assign Qbar = ~Q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: expected Q values are queued as each stimulus step
// is driven and popped/compared one time unit after the clock edge that produces them.
module tb_d_flip_flop;

    localparam int unsigned W = 4;
    localparam logic [W-1:0] RV = '0;

`ifdef D_FLIP_FLOP_RST_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic         clk;
    logic         reset;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Qbar;

    logic [W-1:0] exp_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;

    d_flip_flop #(
        .WIDTH      (W),
        .RESET_VALUE(RV)
    ) dut (
        .clk (clk),
        .reset(reset),
        .D   (D),
        .Q   (Q),
        .Qbar(Qbar)
    );

    // Rising edges at 20, 40, 60, ...; falling edges at 10, 30, ...
    initial begin
        clk = 1'b1;
        forever #10 clk = ~clk;
    end

    // Pop the oldest expectation and compare both outputs against it
    task automatic check(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed Q=%h", tag, Q);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            assert (Q === e) else begin
                n_fail++;
                $error("FAIL %s: Q observed %h expected %h", tag, Q, e);
            end
            n_cmp++;
            assert (Qbar === ~e) else begin
                n_fail++;
                $error("FAIL %s: Qbar observed %h expected %h", tag, Qbar, ~e);
            end
        end
    endtask

    // Drive D, queue the value Q must show after the next rising edge, then check it
    task automatic step(input logic [W-1:0] d, input logic [W-1:0] e, input string tag);
        D = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Edges after a release that must still hold RESET_VALUE (none without the synchronizer)
    task automatic sync_hold(input string tag);
        for (int i = 0; i < SYNC; i++) begin
            step({W{1'b1}}, RV, tag);
        end
    endtask

    initial begin
        logic [W-1:0] r;

        // Power-up reset: outputs at reset value regardless of D
        reset = 1'b0;
        D     = 4'hA;
        #1;
        exp_q.push_back(RV);
        check("por");
        D = 4'h5;
        #6;
        exp_q.push_back(RV);
        check("por_d");

        // Release between edges (t=10); first capture per synchronizer depth
        #3;
        reset = 1'b1;
        sync_hold("sync_hold_por");
        step(4'h1, 4'h1, "cap_1");
        step(4'h0, 4'h0, "cap_0");
        step(4'h1, 4'h1, "cap_1b");

        // Random stream
        for (int i = 0; i < 10; i++) begin
            r = W'($urandom_range(0, (1 << W) - 1));
            step(r, r, "rand");
        end

        // Mid-cycle reset 5 units after an edge with Q all ones
        step(4'hF, 4'hF, "pre_mid");
        #4;
        reset = 1'b0;
        exp_q.push_back(RV);
        #1;
        check("mid_rst");
        step(4'hA, RV, "mid_rst_hold");

        // Release on a falling edge, then resume capturing
        #9;
        reset = 1'b1;
        sync_hold("sync_hold_mid");
        step(4'h5, 4'h5, "rel_cap");

        // Reset/clock coincidence: release lands in the same timestep as a rising edge.
        // Non-blocking update so the register evaluates that edge with reset still low.
        reset = 1'b0;
        exp_q.push_back(RV);
        #1;
        check("coin_pre");
        D = 4'hF;
        exp_q.push_back(RV);
        @(posedge clk);
        reset <= 1'b1;
        #1;
        check("coin_edge");
        sync_hold("sync_hold_coin");
        step(4'hF, 4'hF, "coin_next");
        step(4'h6, 4'h6, "coin_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #50000;
        $display("FAIL timeout: run did not reach summary, observed t=%0t limit 50000", $time);
        $fatal(1, "timeout");
    end

endmodule
